// File: rtl/draw_scheduler.sv
// Sequences the blankboard and squaremapper engines onto the single VGA plot path.
// Latency: a queued square starts two cycles after its push from IDLE (IDLE->LOAD->SQ).
// Backpressure: cmd_ready = !full (low in RST); an offer while full is dropped, so hold cmd_valid.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_*      square command push into the FIFO
//   clear_req, clear_colour         board-clear request pulse and its colour
//   blank_start/blank_done, blank_* blankboard handshake, colour and pixel inputs
//   sq_start/sq_done, sq_*          squaremapper handshake, operands and pixel inputs
//   vga_x/vga_y/vga_colour/vga_plot muxed pixel path to the adapter
//   busy, draw_count                not-IDLE flag, completed square draws (wraps)
module draw_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_x,
  input  logic [3:0]       cmd_y,
  input  logic             cmd_player,
  input  logic [1:0]       cmd_attack,
  input  logic [2:0]       cmd_colour,
  input  logic             clear_req,
  input  logic [2:0]       clear_colour,
  output logic             blank_start,
  output logic [2:0]       blank_colour,
  input  logic             blank_done,
  input  logic [8:0]       blank_x,
  input  logic [7:0]       blank_y,
  input  logic [2:0]       blank_col,
  input  logic             blank_plot,
  output logic             sq_start,
  output logic [3:0]       sq_x,
  output logic [3:0]       sq_y,
  output logic             sq_player,
  output logic [1:0]       sq_attack,
  output logic [2:0]       sq_colour,
  input  logic             sq_done,
  input  logic [8:0]       sq_vx,
  input  logic [7:0]       sq_vy,
  input  logic [2:0]       sq_col,
  input  logic             sq_plot,
  output logic [8:0]       vga_x,
  output logic [7:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic [CNT_W-1:0] draw_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       player;
    logic [1:0] attack;
    logic [2:0] colour;
  } sq_cmd_t;

  typedef enum logic [2:0] {
    ST_RST,
    ST_BLANK,
    ST_IDLE,
    ST_LOAD,
    ST_SQ,
    ST_REL
  } state_t;

  state_t  state, state_nxt;
  sq_cmd_t fifo_mem [FIFO_DEPTH];
  sq_cmd_t cmd_in, fifo_head, sq_op;
  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic fifo_empty, fifo_full, push, pop;
  logic clear_acc, clear_pend;

  assign cmd_in     = {cmd_x, cmd_y, cmd_player, cmd_attack, cmd_colour};
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // Ready is taken from the pre-pop occupancy, so a pop never opens a slot in the same cycle.
  assign cmd_ready  = (state != ST_RST) && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == ST_LOAD) && !fifo_empty;
  assign clear_acc  = clear_req && (state != ST_RST);
  assign busy       = (state != ST_IDLE);

  assign sq_x      = sq_op.x;
  assign sq_y      = sq_op.y;
  assign sq_player = sq_op.player;
  assign sq_attack = sq_op.attack;
  assign sq_colour = sq_op.colour;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    blank_start = 1'b0;
    sq_start    = 1'b0;
    vga_x       = '0;
    vga_y       = '0;
    vga_colour  = '0;
    vga_plot    = 1'b0;
    case (state)
      ST_RST:   state_nxt = ST_BLANK;
      ST_BLANK: begin
        blank_start = 1'b1;
        vga_x       = blank_x;
        vga_y       = blank_y;
        vga_colour  = blank_col;
        vga_plot    = blank_plot;
        if (blank_done) state_nxt = ST_REL;
      end
      ST_IDLE: begin
        if (clear_pend)       state_nxt = ST_BLANK;
        else if (!fifo_empty) state_nxt = ST_LOAD;
      end
      ST_LOAD:  state_nxt = ST_SQ;
      ST_SQ: begin
        sq_start   = 1'b1;
        vga_x      = sq_vx;
        vga_y      = sq_vy;
        vga_colour = sq_col;
        vga_plot   = sq_plot;
        if (sq_done) state_nxt = ST_REL;
      end
      // A cycle with both starts low lets an engine with a sticky done re-arm.
      ST_REL:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_RST;
    endcase
  end

  // Queue storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      clear_pend   <= 1'b0;
      blank_colour <= 3'b000;
      sq_op        <= '0;
      draw_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        sq_op  <= fifo_head;
      end
      if (clear_acc) blank_colour <= clear_colour;
      // A new request on the same edge as entry to BLANK stays pending rather than being lost.
      if (clear_acc)
        clear_pend <= 1'b1;
      else if (state == ST_IDLE && clear_pend)
        clear_pend <= 1'b0;
      if (state == ST_SQ && sq_done) draw_count <= draw_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_x, cmd_y;
  logic       cmd_player;
  logic [1:0] cmd_attack;
  logic [2:0] cmd_colour;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       blank_start;
  logic [2:0] blank_colour;
  logic       blank_done;
  logic [8:0] blank_x;
  logic [7:0] blank_y;
  logic [2:0] blank_col;
  logic       blank_plot;
  logic       sq_start;
  logic [3:0] sq_x, sq_y;
  logic       sq_player;
  logic [1:0] sq_attack;
  logic [2:0] sq_colour;
  logic       sq_done;
  logic [8:0] sq_vx;
  logic [7:0] sq_vy;
  logic [2:0] sq_col;
  logic       sq_plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] draw_count;

  int checks;
  int failures;

  typedef struct packed {
    logic       is_blank;
    logic [3:0] x;
    logic [3:0] y;
    logic       p;
    logic [1:0] a;
    logic [2:0] c;
  } ev_t;

  // Expected engine starts, in order; squares carry operands, blanks carry the colour.
  ev_t exp_q[$];

  draw_scheduler #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_player(cmd_player),
    .cmd_attack(cmd_attack), .cmd_colour(cmd_colour),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .blank_start(blank_start), .blank_colour(blank_colour), .blank_done(blank_done),
    .blank_x(blank_x), .blank_y(blank_y), .blank_col(blank_col), .blank_plot(blank_plot),
    .sq_start(sq_start), .sq_x(sq_x), .sq_y(sq_y), .sq_player(sq_player),
    .sq_attack(sq_attack), .sq_colour(sq_colour), .sq_done(sq_done),
    .sq_vx(sq_vx), .sq_vy(sq_vy), .sq_col(sq_col), .sq_plot(sq_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .draw_count(draw_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  function automatic ev_t mk_sq(input logic [3:0] x, input logic [3:0] y, input logic p,
                                input logic [1:0] a, input logic [2:0] c);
    ev_t e;
    e = '{is_blank: 1'b0, x: x, y: y, p: p, a: a, c: c};
    return e;
  endfunction

  function automatic ev_t mk_blank(input logic [2:0] c);
    ev_t e;
    e = '{is_blank: 1'b1, x: 4'd0, y: 4'd0, p: 1'b0, a: 2'd0, c: c};
    return e;
  endfunction

  function automatic ev_t mk_rand();
    return mk_sq(4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 3'($urandom));
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input ev_t e);
    cmd_valid  = 1'b1;
    cmd_x      = e.x;
    cmd_y      = e.y;
    cmd_player = e.p;
    cmd_attack = e.a;
    cmd_colour = e.c;
  endtask

  // Scoreboard: every rising start is matched against the head of exp_q.
  logic prev_sq, prev_bl;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sq = 1'b0;
      prev_bl = 1'b0;
    end else begin
      if (sq_start && !prev_sq) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sq_start_unexpected got a square start, expected none");
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.is_blank || {sq_x, sq_y, sq_player, sq_attack, sq_colour} !== {e.x, e.y, e.p, e.a, e.c}) begin
            failures++;
            $display("FAIL sq_order got square x=%0d y=%0d p=%0d a=%0d c=%0d, expected blank=%0d x=%0d y=%0d p=%0d a=%0d c=%0d",
                     sq_x, sq_y, sq_player, sq_attack, sq_colour, e.is_blank, e.x, e.y, e.p, e.a, e.c);
          end
        end
      end
      if (blank_start && !prev_bl) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL blank_start_unexpected got a blank start, expected none");
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (!e.is_blank || blank_colour !== e.c) begin
            failures++;
            $display("FAIL blank_order got blank colour=%0d, expected blank=%0d colour=%0d",
                     blank_colour, e.is_blank, e.c);
          end
        end
      end
      prev_sq = sq_start;
      prev_bl = blank_start;
    end
  end

  task automatic run_squares(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 20 && sq_start !== 1'b1; c++) tick();
      checks++;
      if (sq_start !== 1'b1) begin
        failures++;
        $display("FAIL run_squares_timeout square %0d: sq_start=%0b, expected 1", k, sq_start);
      end
      sq_done = 1'b1;
      tick();
      sq_done = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_player = 1'b0; cmd_attack = '0; cmd_colour = '0;
    clear_req = 1'b0; clear_colour = '0;
    blank_done = 1'b0; sq_done = 1'b0;
    blank_x = 9'h1A5; blank_y = 8'h5C; blank_col = 3'b101; blank_plot = 1'b1;
    sq_vx = 9'h0F3; sq_vy = 8'h21; sq_col = 3'b110; sq_plot = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, blank_start, sq_start} !== 3'b000) begin
      failures++;
      $display("FAIL reset_handshake ready/blank_start/sq_start=%b, expected 000", {cmd_ready, blank_start, sq_start});
    end
    checks++;
    if ({vga_x, vga_y, vga_colour, vga_plot} !== 21'd0) begin
      failures++;
      $display("FAIL reset_vga x=%0d y=%0d c=%0d plot=%0b, expected all 0", vga_x, vga_y, vga_colour, vga_plot);
    end
    checks++;
    if ({draw_count, blank_colour, sq_x, sq_y, sq_player, sq_attack, sq_colour} !== 25'd0) begin
      failures++;
      $display("FAIL reset_regs count=%0d blank_colour=%0d sq_x=%0d sq_y=%0d, expected 0",
               draw_count, blank_colour, sq_x, sq_y);
    end
  endtask

  task automatic test_powerup();
    exp_q.push_back(mk_blank(3'b000));
    // Offers during the RST cycle must be ignored.
    rst_n = 1'b1;
    clear_req = 1'b1; clear_colour = 3'b111;
    drive_cmd(mk_sq(4'd9, 4'd9, 1'b0, 2'd1, 3'b011));
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL powerup_rst_ready cmd_ready=%0b, expected 0", cmd_ready);
    end
    tick();
    clear_req = 1'b0; cmd_valid = 1'b0;
    checks++;
    if (blank_start !== 1'b1 || busy !== 1'b1 || blank_colour !== 3'b000) begin
      failures++;
      $display("FAIL powerup_blank_start start=%0b busy=%0b colour=%0d, expected 1/1/0", blank_start, busy, blank_colour);
    end
    for (int i = 0; i < 99; i++) begin
      blank_x = 9'($urandom); blank_y = 8'($urandom); blank_col = 3'($urandom); blank_plot = 1'($urandom);
      #1;
      checks++;
      if (blank_start !== 1'b1 || {vga_x, vga_y, vga_colour, vga_plot} !== {blank_x, blank_y, blank_col, blank_plot}) begin
        failures++;
        $display("FAIL powerup_mux cycle %0d start=%0b vga=%h, expected start=1 vga=%h", i, blank_start,
                 {vga_x, vga_y, vga_colour, vga_plot}, {blank_x, blank_y, blank_col, blank_plot});
      end
      tick();
    end
    blank_plot = 1'b1;
    blank_done = 1'b1;
    tick();
    checks++;
    if (blank_start !== 1'b0 || vga_plot !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL powerup_rel start=%0b plot=%0b busy=%0b, expected 0/0/1", blank_start, vga_plot, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || blank_start !== 1'b0) begin
      failures++;
      $display("FAIL powerup_idle busy=%0b start=%0b, expected 0/0", busy, blank_start);
    end
    blank_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL powerup_stay_idle busy=%0b ready=%0b, expected 0/1", busy, cmd_ready);
    end
  endtask

  task automatic test_single();
    ev_t e;
    e = mk_sq(4'd3, 4'd7, 1'b1, 2'd2, 3'b100);
    exp_q.push_back(e);
    drive_cmd(e);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (sq_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle start=%0b busy=%0b, expected 0/0", sq_start, busy);
    end
    tick();
    checks++;
    if (sq_start !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_load start=%0b busy=%0b, expected 0/1", sq_start, busy);
    end
    tick();
    checks++;
    if (sq_start !== 1'b1) begin
      failures++;
      $display("FAIL single_sq_start sq_start=%0b, expected 1", sq_start);
    end
    for (int i = 0; i < 5; i++) begin
      sq_vx = 9'($urandom); sq_vy = 8'($urandom); sq_col = 3'($urandom); sq_plot = i[0];
      #1;
      checks++;
      if ({sq_x, sq_y, sq_player, sq_attack, sq_colour} !== {4'd3, 4'd7, 1'b1, 2'd2, 3'b100}) begin
        failures++;
        $display("FAIL single_operands got %h, expected %h", {sq_x, sq_y, sq_player, sq_attack, sq_colour},
                 {4'd3, 4'd7, 1'b1, 2'd2, 3'b100});
      end
      checks++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== {sq_vx, sq_vy, sq_col, sq_plot}) begin
        failures++;
        $display("FAIL single_mux got %h, expected %h", {vga_x, vga_y, vga_colour, vga_plot}, {sq_vx, sq_vy, sq_col, sq_plot});
      end
      tick();
    end
    sq_done = 1'b1;
    tick();
    sq_done = 1'b0;
    sq_plot = 1'b1;
    #1;
    checks++;
    if (sq_start !== 1'b0 || vga_plot !== 1'b0 || draw_count !== 8'd1) begin
      failures++;
      $display("FAIL single_rel start=%0b plot=%0b count=%0d, expected 0/0/1", sq_start, vga_plot, draw_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_end busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    ev_t e;
    ev_t f[5];
    e = mk_sq(4'd1, 4'd2, 1'b0, 2'd1, 3'b001);
    exp_q.push_back(e);
    drive_cmd(e);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (sq_start !== 1'b1) begin
      failures++;
      $display("FAIL full_first_start sq_start=%0b, expected 1", sq_start);
    end
    for (int k = 0; k < 5; k++) begin
      f[k] = mk_sq(4'(k + 4), 4'(9 - k), k[0], 2'(k), 3'(k + 2));
      checks++;
      if (cmd_ready !== (k < 4)) begin
        failures++;
        $display("FAIL full_ready offer %0d cmd_ready=%0b, expected %0b", k, cmd_ready, (k < 4));
      end
      if (k < 4) exp_q.push_back(f[k]);
      drive_cmd(f[k]);
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold cmd_ready=%0b, expected 0", cmd_ready);
    end
    sq_done = 1'b1;
    tick();
    sq_done = 1'b0;
    tick();
    tick();
    // LOAD with a full FIFO: the pop must not open a slot for this cycle's offer.
    checks++;
    if (busy !== 1'b1 || sq_start !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_load busy=%0b start=%0b ready=%0b, expected 1/0/0", busy, sq_start, cmd_ready);
    end
    drive_cmd(f[4]);
    tick();
    checks++;
    if (sq_start !== 1'b1 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop start=%0b ready=%0b, expected 1/1", sq_start, cmd_ready);
    end
    exp_q.push_back(f[4]);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refill cmd_ready=%0b, expected 0", cmd_ready);
    end
    run_squares(5);
    checks++;
    if (draw_count !== 8'd7 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain count=%0d pending=%0d, expected 7/0", draw_count, exp_q.size());
    end
  endtask

  task automatic test_clear_priority();
    ev_t g, h, i2;
    g = mk_sq(4'd11, 4'd12, 1'b1, 2'd3, 3'b111);
    h = mk_sq(4'd13, 4'd14, 1'b0, 2'd0, 3'b010);
    i2 = mk_sq(4'd15, 4'd0, 1'b1, 2'd1, 3'b001);
    exp_q.push_back(g);
    drive_cmd(g);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    drive_cmd(h);
    tick();
    drive_cmd(i2);
    tick();
    cmd_valid = 1'b0;
    clear_req = 1'b1; clear_colour = 3'b010;
    tick();
    clear_req = 1'b0;
    exp_q.push_back(mk_blank(3'b010));
    checks++;
    if (blank_colour !== 3'b010 || sq_start !== 1'b1 || blank_start !== 1'b0) begin
      failures++;
      $display("FAIL clear_latch colour=%0d sq_start=%0b blank_start=%0b, expected 2/1/0", blank_colour, sq_start, blank_start);
    end
    sq_done = 1'b1;
    tick();
    sq_done = 1'b0;
    checks++;
    if (draw_count !== 8'd8) begin
      failures++;
      $display("FAIL clear_count count=%0d, expected 8", draw_count);
    end
    tick();
    tick();
    checks++;
    if (blank_start !== 1'b1 || sq_start !== 1'b0) begin
      failures++;
      $display("FAIL clear_priority blank_start=%0b sq_start=%0b, expected 1/0", blank_start, sq_start);
    end
    // A request during BLANK must produce a second clear before the queued squares.
    clear_req = 1'b1; clear_colour = 3'b011;
    tick();
    clear_req = 1'b0;
    exp_q.push_back(mk_blank(3'b011));
    exp_q.push_back(h);
    exp_q.push_back(i2);
    blank_done = 1'b1;
    tick();
    blank_done = 1'b0;
    tick();
    tick();
    checks++;
    if (blank_start !== 1'b1 || blank_colour !== 3'b011) begin
      failures++;
      $display("FAIL clear_second blank_start=%0b colour=%0d, expected 1/3", blank_start, blank_colour);
    end
    blank_done = 1'b1;
    tick();
    blank_done = 1'b0;
    tick();
    run_squares(2);
    checks++;
    if (draw_count !== 8'd10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL clear_drain count=%0d pending=%0d, expected 10/0", draw_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ev_t e;
    e = mk_rand();
    exp_q.push_back(e);
    drive_cmd(e);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      e = mk_rand();
      exp_q.push_back(e);
      drive_cmd(e);
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (sq_start !== 1'b1 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre start=%0b ready=%0b, expected 1/1", sq_start, cmd_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sq_start !== 1'b0 || cmd_ready !== 1'b0 || draw_count !== 8'd0 || blank_colour !== 3'b000) begin
      failures++;
      $display("FAIL rmid_async start=%0b ready=%0b count=%0d colour=%0d, expected 0/0/0/0",
               sq_start, cmd_ready, draw_count, blank_colour);
    end
    exp_q.delete();
    exp_q.push_back(mk_blank(3'b000));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (blank_start !== 1'b1) begin
      failures++;
      $display("FAIL rmid_blank blank_start=%0b, expected 1", blank_start);
    end
    blank_done = 1'b1;
    tick();
    blank_done = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b0 || sq_start !== 1'b0) begin
        failures++;
        $display("FAIL rmid_fifo_empty cycle %0d busy=%0b start=%0b, expected 0/0", k, busy, sq_start);
      end
      tick();
    end
    checks++;
    if (draw_count !== 8'd0 || cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rmid_end count=%0d ready=%0b pending=%0d, expected 0/1/0", draw_count, cmd_ready, exp_q.size());
    end
  endtask

  task automatic test_sticky_done();
    ev_t e;
    sq_done = 1'b1;
    e = mk_rand(); exp_q.push_back(e); drive_cmd(e);
    tick();
    e = mk_rand(); exp_q.push_back(e); drive_cmd(e);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (sq_start !== 1'b1 || draw_count !== 8'(i)) begin
        failures++;
        $display("FAIL sticky_sq square %0d start=%0b count=%0d, expected 1/%0d", i, sq_start, draw_count, 8'(i));
      end
      if (i + 2 < 256) begin
        e = mk_rand();
        exp_q.push_back(e);
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL sticky_ready square %0d cmd_ready=%0b, expected 1", i, cmd_ready);
        end
        drive_cmd(e);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (sq_start !== 1'b0 || busy !== 1'b1 || draw_count !== 8'(i + 1)) begin
        failures++;
        $display("FAIL sticky_rel square %0d start=%0b busy=%0b count=%0d, expected 0/1/%0d",
                 i, sq_start, busy, draw_count, 8'(i + 1));
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL sticky_idle square %0d busy=%0b, expected 0", i, busy);
      end
      if (i < 255) begin
        tick();
        checks++;
        if (busy !== 1'b1 || sq_start !== 1'b0) begin
          failures++;
          $display("FAIL sticky_load square %0d busy=%0b start=%0b, expected 1/0", i, busy, sq_start);
        end
        tick();
      end
    end
    sq_done = 1'b0;
    checks++;
    if (exp_q.size() != 0 || draw_count !== 8'd0) begin
      failures++;
      $display("FAIL sticky_end pending=%0d count=%0d, expected 0/0", exp_q.size(), draw_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev_sq = 1'b0;
    prev_bl = 1'b0;
    test_reset();
    test_powerup();
    test_single();
    test_fifo_full();
    test_clear_priority();
    test_reset_mid();
    test_sticky_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
